// File: rtl/shift_ctrl_pkg.sv
// Shared types for the shift-register sequencer: register select codes, FSM states, bit order.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        SR_HOLD = 2'b00,
        SR_SHL  = 2'b01,
        SR_SHR  = 2'b10,
        SR_LOAD = 2'b11
    } sr_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_PARITY,
        ST_RESP
    } state_e;

    typedef enum logic {
        DIR_MSB_FIRST = 1'b0,
        DIR_LSB_FIRST = 1'b1
    } dir_e;

endpackage

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold, shift-left, shift-right, or parallel load.
module univ_shift_reg
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  sr_sel_e          sel,
    input  logic             msb_in,
    input  logic             lsb_in,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] shl_v;
    logic [WIDTH-1:0] shr_v;

    // A one-bit register has no neighbours; both shifts degenerate to taking the serial input.
    if (WIDTH == 1) begin : g_w1
        assign shl_v = lsb_in;
        assign shr_v = msb_in;
    end else begin : g_wn
        assign shl_v = {q_q[WIDTH-2:0], lsb_in};
        assign shr_v = {msb_in, q_q[WIDTH-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q_q <= '0;
        end else begin
            unique case (sel)
                SR_HOLD: q_q <= q_q;
                SR_SHL:  q_q <= shl_v;
                SR_SHR:  q_q <= shr_v;
                SR_LOAD: q_q <= par_in;
            endcase
        end
    end

    assign q = q_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Word-to-serial full-duplex sequencer around univ_shift_reg.
// Define SHIFT_PARITY_EN to append an even-parity bit and report receive parity errors on rsp_err.
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    dir_e             dir_q;
    logic [WIDTH-1:0] q;
    sr_sel_e          sel;
    logic             msb_in;
    logic             lsb_in;
    logic             last_bit;

`ifdef SHIFT_PARITY_EN
    logic tx_par_q;
    logic rx_par_q;
`endif

    univ_shift_reg #(.WIDTH(WIDTH)) u_sr (
        .clk    (clk),
        .rst_b  (rst_b),
        .sel    (sel),
        .msb_in (msb_in),
        .lsb_in (lsb_in),
        .par_in (cmd_data),
        .q      (q)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel    = SR_HOLD;
        msb_in = 1'b0;
        lsb_in = 1'b0;
        case (state_q)
            ST_IDLE: if (cmd_valid) sel = SR_LOAD;
            ST_SHIFT: begin
                if (dir_q == DIR_MSB_FIRST) begin
                    sel    = SR_SHL;
                    lsb_in = ser_in;
                end else begin
                    sel    = SR_SHR;
                    msb_in = ser_in;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dir_q    <= DIR_MSB_FIRST;
`ifdef SHIFT_PARITY_EN
            tx_par_q <= 1'b0;
            rx_par_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        dir_q    <= dir_e'(cmd_dir);
                        cnt_q    <= '0;
`ifdef SHIFT_PARITY_EN
                        tx_par_q <= ^cmd_data;
`endif
                        state_q  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
`ifdef SHIFT_PARITY_EN
                        state_q <= ST_PARITY;
`else
                        state_q <= ST_RESP;
`endif
                    end
                end
                ST_PARITY: begin
`ifdef SHIFT_PARITY_EN
                    rx_par_q <= ser_in;
`endif
                    state_q  <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // All outputs decode registered state, so nothing combinational reaches the serial pins.
    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_valid ? q : '0;

`ifdef SHIFT_PARITY_EN
    assign ser_valid = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
    assign ser_out   = (state_q == ST_SHIFT)
                       ? ((dir_q == DIR_LSB_FIRST) ? q[0] : q[WIDTH-1])
                       : ((state_q == ST_PARITY) & tx_par_q);
    assign rsp_err   = rsp_valid & (rx_par_q ^ (^q));
`else
    assign ser_valid = (state_q == ST_SHIFT);
    assign ser_out   = (state_q == ST_SHIFT)
                       & ((dir_q == DIR_LSB_FIRST) ? q[0] : q[WIDTH-1]);
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl (WIDTH=4); covers SHIFT_PARITY_EN when that macro is defined.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_dir;
    logic [3:0] cmd_data;
    logic       ser_in;
    logic       ser_out;
    logic       ser_valid;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_err;
    logic       busy;

    logic       loop_en;
    logic       flip_en;
    logic       sin_drv;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       dir;
        logic [3:0] data;
        logic       loop;     // ser_in follows ser_out
        logic       sin;      // constant ser_in when not looping
        logic       flip;     // invert the looped-back parity bit
        logic [3:0] exp_ser;  // bits in transmit order, first bit in [3]
        logic [3:0] exp_rsp;
    } vec_t;

    vec_t vecs[7];

    assign ser_in = loop_en ? (ser_out ^ flip_en) : sin_drv;

    shift_seq_ctrl dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_data  (cmd_data),
        .ser_in    (ser_in),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one word, check every serial bit, optionally stall the response, then release it.
    task automatic run_word(input vec_t v, input string tag, input int hold);
        logic exp_err;
        loop_en   = v.loop;
        sin_drv   = v.sin;
        flip_en   = 1'b0;
        rsp_ready = 1'b0;
        cmd_dir   = v.dir;
        cmd_data  = v.data;
        cmd_valid = 1'b1;
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_idle_busy"}, busy, 0);
        step();
        cmd_valid = 1'b0;
        cmd_data  = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_bit%0d_valid", tag, i), ser_valid, 1);
            check($sformatf("%s_bit%0d_out", tag, i), ser_out, v.exp_ser[3-i]);
            check($sformatf("%s_bit%0d_rdy", tag, i), cmd_ready, 0);
            step();
        end
        exp_err = 1'b0;
`ifdef SHIFT_PARITY_EN
        flip_en = v.flip;
        check({tag, "_par_valid"}, ser_valid, 1);
        check({tag, "_par_out"}, ser_out, ^v.data);
        exp_err = (v.loop ? ((^v.data) ^ v.flip) : v.sin) ^ (^v.exp_rsp);
        step();
        flip_en = 1'b0;
`endif
        for (int h = 0; h <= hold; h++) begin
            check($sformatf("%s_rsp_valid%0d", tag, h), rsp_valid, 1);
            check($sformatf("%s_rsp_data%0d", tag, h), rsp_data, v.exp_rsp);
            check($sformatf("%s_rsp_err%0d", tag, h), rsp_err, exp_err);
            check($sformatf("%s_rsp_ser_valid%0d", tag, h), ser_valid, 0);
            check($sformatf("%s_rsp_cmd_ready%0d", tag, h), cmd_ready, 0);
            if (h < hold) begin
                cmd_valid = (h == 1);
                cmd_data  = 4'b0101;
                step();
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_done_rsp_valid"}, rsp_valid, 0);
        check({tag, "_done_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        vecs[0] = '{dir: 1'b0, data: 4'b1011, loop: 1'b1, sin: 1'b0, flip: 1'b0, exp_ser: 4'b1011, exp_rsp: 4'b1011};
        vecs[1] = '{dir: 1'b1, data: 4'b1011, loop: 1'b0, sin: 1'b1, flip: 1'b0, exp_ser: 4'b1101, exp_rsp: 4'b1111};
        vecs[2] = '{dir: 1'b0, data: 4'b0110, loop: 1'b0, sin: 1'b0, flip: 1'b0, exp_ser: 4'b0110, exp_rsp: 4'b0000};
        vecs[3] = '{dir: 1'b1, data: 4'b1001, loop: 1'b0, sin: 1'b0, flip: 1'b0, exp_ser: 4'b1001, exp_rsp: 4'b0000};
        vecs[4] = '{dir: 1'b0, data: 4'b0000, loop: 1'b0, sin: 1'b1, flip: 1'b0, exp_ser: 4'b0000, exp_rsp: 4'b1111};
        vecs[5] = '{dir: 1'b1, data: 4'b1100, loop: 1'b1, sin: 1'b0, flip: 1'b0, exp_ser: 4'b0011, exp_rsp: 4'b1100};
        vecs[6] = '{dir: 1'b0, data: 4'b1011, loop: 1'b1, sin: 1'b0, flip: 1'b1, exp_ser: 4'b1011, exp_rsp: 4'b1011};

        rst_b     = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir   = 1'b0;
        cmd_data  = 4'h0;
        rsp_ready = 1'b0;
        loop_en   = 1'b0;
        flip_en   = 1'b0;
        sin_drv   = 1'b0;

        // Reset values before any clock edge.
        #3;
        check("rst_busy", busy, 0);
        check("rst_ser_valid", ser_valid, 0);
        check("rst_ser_out", ser_out, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst_b = 1'b1;
        step();

        for (int k = 0; k < 7; k++) begin
            run_word(vecs[k], $sformatf("vec%0d", k), 0);
        end

        // Stalled response with a command offered during RESP: nothing may be accepted.
        run_word(vecs[1], "stall", 3);
        step();
        check("stall_not_taken_busy", busy, 0);
        check("stall_not_taken_rdy", cmd_ready, 1);

        // Reset asserted during bit 2 drops the word immediately.
        loop_en   = 1'b1;
        cmd_dir   = 1'b0;
        cmd_data  = 4'b1011;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        step();
        check("mid_busy_before", busy, 1);
        rst_b = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ser_valid", ser_valid, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("mid_rst_no_rsp%0d", c), rsp_valid, 0);
        end
        @(negedge clk);
        rst_b = 1'b1;
        step();
        run_word('{dir: 1'b0, data: 4'b0110, loop: 1'b1, sin: 1'b0, flip: 1'b0,
                   exp_ser: 4'b0110, exp_rsp: 4'b0110}, "after_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
